lc3b_mem_responder: RTL and testbench
=====================================

# lc3b_mem_responder

Memory-side responder for the LC-3b processor's memory bus. It accepts read and write requests from the control path and datapath, and holds a byte-addressable, word-organised storage array. It services each request after a fixed, programmable number of wait states and returns data together with a one-cycle `ready` strobe. This block is the slave end of the interface driven by the controller's `memRd`/`memWr` and byte/word select, and it replaces the zero-latency memory model with a realistic multi-cycle responder.

## Interface
- `DEPTH_WORDS`, 256: number of 16-bit words in the array; power of two.
- `WAIT_CYCLES`, 2: wait states inserted between request acceptance and response; range 0–15.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_rd`  in  1  read request, sampled only in IDLE.
- `mem_wr`  in  1  write request, sampled only in IDLE.
- `byte_acc`  in  1  1 = byte access (LDB/STB), 0 = word access.
- `addr`  in  16  byte address.
- `wdata`  in  16  write data; byte writes use `wdata[7:0]`.
- `rdata`  out  16  read data, valid while `ready`=1.
- `ready`  out  1  one-cycle completion strobe.
- `err`  out  1  error status, qualified by `ready`.
- `busy`  out  1  1 whenever state ≠ IDLE.

## Operation
- States:
  - IDLE: `busy`=0.
  - WAIT: counter loaded with `WAIT_CYCLES`, decremented each cycle.
  - RESP: `ready`=1 for exactly one cycle.
- IDLE→WAIT on any edge where `mem_rd|mem_wr`=1. On that edge `addr`, `wdata`, `byte_acc`, the request type, and the error condition are latched. The requester need not hold its inputs after acceptance.
- WAIT→RESP on the edge where the counter is 0.
- RESP→IDLE unconditionally.
- Requests arriving in WAIT or RESP are ignored, not queued. The earliest next acceptance is the edge that ends RESP's cycle in IDLE, i.e. one idle cycle between back-to-back transactions.
- Array index = `addr[k:1]` with k = log2(`DEPTH_WORDS`). Upper address bits are ignored, so addresses wrap modulo 2·`DEPTH_WORDS` bytes.
- Word read: `rdata` = array[index].
- Byte read:
  - `rdata[7:0]` = low byte if `addr[0]`=0, high byte if `addr[0]`=1.
  - `rdata[15:8]` = 0. Sign extension is the datapath's job.
- Word write: array[index] ← `wdata`.
- Byte write: only the lane selected by `addr[0]` is written, with `wdata[7:0]`. The other lane is unchanged.
- Error conditions (latched at acceptance):
  - Word access with `addr[0]`=1 (misaligned).
  - `mem_rd` and `mem_wr` both 1.
  - Effect: no array write, `rdata`=0, `err`=1 in RESP.
- Array commit and read capture occur on the WAIT→RESP edge. `rdata` is registered and holds its value until the next RESP. Outside RESP, `rdata` is don't-care for consumers.
- The array is not reset. Contents are preserved across `reset`.

## Timing
- Reset values: state=IDLE, `ready`=0, `err`=0, `busy`=0, `rdata`=0x0000, counter=0.
- Reset asserted mid-transaction:
  - Immediate return to IDLE, all outputs at reset values.
  - A pending write that has not yet reached the WAIT→RESP edge is dropped.
- Latency:
  - Accept edge = E. `ready`=1 during the cycle after edge E+`WAIT_CYCLES`+1, and falls after edge E+`WAIT_CYCLES`+2.
  - `WAIT_CYCLES`=0 gives `ready` the cycle after E+1.
- Throughput: one transaction per `WAIT_CYCLES`+3 cycles when requests are held continuously.
- `busy` rises the cycle after the accept edge and falls the cycle after RESP.
- `err` is 1 only while `ready`=1.

## Test plan
- Reset, then word write then read, `WAIT_CYCLES`=2: write 0xBEEF to addr 0x0010, then read addr 0x0010 → `ready` pulses 3 edges after each accept, `rdata`=0xBEEF, `err`=0.
- Byte lanes: word-write 0x1234 to 0x0020, byte-write 0xAB to 0x0021, then word-read 0x0020 → 0xAB34. Byte-read 0x0021 → 0x00AB. Byte-read 0x0020 → 0x0034.
- Errors:
  - Word write 0x5555 to misaligned 0x0031 → `ready`=1, `err`=1, `rdata`=0.
  - Subsequent word-read of 0x0030 → unchanged prior value.
  - `mem_rd`=`mem_wr`=1 → `err`=1, no write.
- Wrap and ignore, `DEPTH_WORDS`=256:
  - Write 0x7777 to 0x0202, read 0x0002 → 0x7777.
  - A second request pulsed during WAIT produces no extra `ready`.
- Reset mid-transaction: accept write of 0xCAFE to 0x0040, assert `reset` during WAIT → outputs return to reset values. After release, read 0x0040 → the previous contents, not 0xCAFE.
- `WAIT_CYCLES`=0 with back-to-back reads held high → `ready` every 3rd cycle, `busy` low for exactly one cycle between transactions.

Source files
------------

// File: rtl/lc3b_mem_responder.sv
// LC-3b memory-side responder: word-organised byte-addressable array that
// answers each read/write after WAIT_CYCLES wait states with a one-cycle
// ready strobe. Requests seen while busy are dropped, not queued.
// DEPTH_WORDS must be a power of two no larger than 16384.
module lc3b_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic        byte_acc,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);
    localparam int K = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Everything the transaction needs after the accept edge; the requester
    // is free to change its inputs once the request is taken.
    typedef struct packed {
        logic         rd;
        logic         wr;
        logic         byte_acc;
        logic         err;
        logic         hi;
        logic [K-1:0] idx;
        logic [15:0]  wdata;
    } req_t;

    state_t      state, state_nxt;
    req_t        req;
    logic [3:0]  cnt;
    logic        accept, commit;
    logic [15:0] mem [DEPTH_WORDS];
    logic [15:0] word_q, rd_val;
    logic        addr_unused;

    // Upper address bits alias onto the array (wrap modulo 2*DEPTH_WORDS bytes).
    assign addr_unused = ^addr[15:K+1];

    assign accept = (state == ST_IDLE) && (mem_rd || mem_wr);
    assign commit = (state == ST_WAIT) && (cnt == 4'd0);

    // State register; async reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and strobe outputs.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        err       = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (mem_rd || mem_wr) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt == 4'd0) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                ready     = 1'b1;
                err       = req.err;
                state_nxt = ST_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read lane selection from the latched request; byte reads zero-extend.
    always_comb begin
        word_q = mem[req.idx];
        rd_val = word_q;
        if (req.byte_acc) rd_val = {8'h00, req.hi ? word_q[15:8] : word_q[7:0]};
    end

    // Request latch, wait counter and registered read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= 4'd0;
            req   <= '0;
            rdata <= 16'h0000;
        end else begin
            if (accept) begin
                cnt          <= 4'(WAIT_CYCLES);
                req.rd       <= mem_rd;
                req.wr       <= mem_wr;
                req.byte_acc <= byte_acc;
                req.err      <= (mem_rd && mem_wr) || (!byte_acc && addr[0]);
                req.hi       <= addr[0];
                req.idx      <= addr[K:1];
                req.wdata    <= wdata;
            end else if (state == ST_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            // Writes and errored requests return zero data.
            if (commit) rdata <= (req.rd && !req.err) ? rd_val : 16'h0000;
        end
    end

    // Storage array; deliberately not reset so contents survive reset.
    always_ff @(posedge clk) begin
        if (commit && req.wr && !req.err) begin
            if (!req.byte_acc)  mem[req.idx]       <= req.wdata;
            else if (req.hi)    mem[req.idx][15:8] <= req.wdata[7:0];
            else                mem[req.idx][7:0]  <= req.wdata[7:0];
        end
    end
endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Self-checking bench for lc3b_mem_responder: one DUT with two wait states,
// one with zero wait states for the back-to-back throughput scenario.
module tb_lc3b_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_rd, mem_wr, byte_acc;
    logic [15:0] addr, wdata, rdata;
    logic        ready, err, busy;
    logic        z_rd, z_wr, z_byte;
    logic [15:0] z_addr, z_wdata, z_rdata;
    logic        z_ready, z_err, z_busy;

    typedef struct packed {
        logic [15:0] rdata;
        logic        err;
        logic        chk;
    } exp_t;

    exp_t q[$];
    exp_t zq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    lc3b_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .byte_acc(byte_acc), .addr(addr), .wdata(wdata), .rdata(rdata),
        .ready(ready), .err(err), .busy(busy)
    );

    lc3b_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .reset(reset), .mem_rd(z_rd), .mem_wr(z_wr),
        .byte_acc(z_byte), .addr(z_addr), .wdata(z_wdata), .rdata(z_rdata),
        .ready(z_ready), .err(z_err), .busy(z_busy)
    );

    // Scoreboard: every ready pops one expected response.
    always @(negedge clk) begin
        exp_t e;
        if (ready) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ready: got ready=1, required no response pending");
            end else begin
                e = q.pop_front();
                if (err !== e.err) begin
                    n_fail++;
                    $display("FAIL resp_err: got %b, required %b", err, e.err);
                end
                if (e.chk) begin
                    n_tests++;
                    if (rdata !== e.rdata) begin
                        n_fail++;
                        $display("FAIL resp_rdata: got %h, required %h", rdata, e.rdata);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (z_ready) begin
            n_tests++;
            if (zq.size() == 0) begin
                n_fail++;
                $display("FAIL z_unexpected_ready: got ready=1, required no response pending");
            end else begin
                e = zq.pop_front();
                if (z_err !== e.err || (e.chk && z_rdata !== e.rdata)) begin
                    n_fail++;
                    $display("FAIL z_resp: got err=%b rdata=%h, required err=%b rdata=%h",
                             z_err, z_rdata, e.err, e.rdata);
                end
            end
        end
    end

    // Drive one request, wait (bounded) for its ready; reports edges from
    // accept to ready, busy just after accept, and busy|ready after RESP.
    task automatic txn(input logic rd, input logic wr, input logic bt,
                       input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] exp_d, input logic exp_e, input logic chk,
                       output int edges, output logic b1, output logic b_end);
        exp_t e;
        @(negedge clk);
        mem_rd = rd; mem_wr = wr; byte_acc = bt; addr = a; wdata = d;
        e.rdata = exp_d; e.err = exp_e; e.chk = chk;
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        mem_rd = 1'b0; mem_wr = 1'b0;
        b1 = busy;
        edges = 0;
        while (!ready && edges < 30) begin
            @(negedge clk);
            edges++;
        end
        if (!ready) q.delete();
        @(negedge clk);
        b_end = busy | ready;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        mem_rd = 0; mem_wr = 0; byte_acc = 0; addr = 0; wdata = 0;
        z_rd = 0; z_wr = 0; z_byte = 0; z_addr = 0; z_wdata = 0;
        repeat (3) @(negedge clk);
        n_tests += 4;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b, required 0", ready); end
        if (err !== 1'b0)   begin n_fail++; $display("FAIL reset_err: got %b, required 0", err); end
        if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h, required 0000", rdata); end
        reset = 1'b1;
    endtask

    task automatic test_word_rw();
        int ed; logic b1, be;
        txn(0, 1, 0, 16'h0010, 16'hBEEF, 16'h0, 0, 0, ed, b1, be);
        n_tests += 3;
        if (ed !== 3)    begin n_fail++; $display("FAIL wr_latency: got %0d edges, required 3", ed); end
        if (b1 !== 1'b1) begin n_fail++; $display("FAIL wr_busy_rise: got %b, required 1", b1); end
        if (be !== 1'b0) begin n_fail++; $display("FAIL wr_busy_fall: got %b, required 0", be); end
        txn(1, 0, 0, 16'h0010, 16'h0, 16'hBEEF, 0, 1, ed, b1, be);
        n_tests++;
        if (ed !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d edges, required 3", ed); end
    endtask

    task automatic test_byte_lanes();
        int ed; logic b1, be;
        txn(0, 1, 0, 16'h0020, 16'h1234, 16'h0, 0, 0, ed, b1, be);
        txn(0, 1, 1, 16'h0021, 16'h55AB, 16'h0, 0, 0, ed, b1, be);
        txn(1, 0, 0, 16'h0020, 16'h0, 16'hAB34, 0, 1, ed, b1, be);
        txn(1, 0, 1, 16'h0021, 16'h0, 16'h00AB, 0, 1, ed, b1, be);
        txn(1, 0, 1, 16'h0020, 16'h0, 16'h0034, 0, 1, ed, b1, be);
        txn(0, 1, 1, 16'h0020, 16'hFFC3, 16'h0, 0, 0, ed, b1, be);
        txn(1, 0, 0, 16'h0020, 16'h0, 16'hABC3, 0, 1, ed, b1, be);
    endtask

    task automatic test_errors();
        int ed; logic b1, be;
        txn(0, 1, 0, 16'h0030, 16'h0F0F, 16'h0, 0, 0, ed, b1, be);
        txn(0, 1, 0, 16'h0031, 16'h5555, 16'h0, 1, 1, ed, b1, be);
        n_tests++;
        if (ed !== 3) begin n_fail++; $display("FAIL err_latency: got %0d edges, required 3", ed); end
        txn(1, 0, 0, 16'h0030, 16'h0, 16'h0F0F, 0, 1, ed, b1, be);
        txn(1, 1, 0, 16'h0030, 16'h9999, 16'h0, 1, 1, ed, b1, be);
        txn(1, 0, 0, 16'h0030, 16'h0, 16'h0F0F, 0, 1, ed, b1, be);
        txn(1, 0, 0, 16'h0031, 16'h0, 16'h0, 1, 1, ed, b1, be);
        txn(1, 0, 1, 16'h0031, 16'h0, 16'h000F, 0, 1, ed, b1, be);
    endtask

    task automatic test_wrap_ignore();
        int ed, nr; logic b1, be;
        exp_t e;
        txn(0, 1, 0, 16'h0202, 16'h7777, 16'h0, 0, 0, ed, b1, be);
        txn(1, 0, 0, 16'h0002, 16'h0, 16'h7777, 0, 1, ed, b1, be);
        // Read, then pulse a write to the same word while the read waits.
        @(negedge clk);
        mem_rd = 1; mem_wr = 0; byte_acc = 0; addr = 16'h0002;
        e.rdata = 16'h7777; e.err = 0; e.chk = 1;
        q.push_back(e);
        @(posedge clk);
        nr = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready) nr++;
            if (i == 0) mem_rd = 0;
            if (i == 1) begin mem_wr = 1; wdata = 16'h1111; end
            if (i == 2) mem_wr = 0;
        end
        n_tests++;
        if (nr !== 1) begin n_fail++; $display("FAIL ignore_ready_count: got %0d, required 1", nr); end
        txn(1, 0, 0, 16'h0002, 16'h0, 16'h7777, 0, 1, ed, b1, be);
    endtask

    task automatic test_reset_mid();
        int ed; logic b1, be;
        txn(0, 1, 0, 16'h0040, 16'h4321, 16'h0, 0, 0, ed, b1, be);
        txn(1, 0, 0, 16'h0010, 16'h0, 16'hBEEF, 0, 1, ed, b1, be);
        @(negedge clk);
        mem_wr = 1; byte_acc = 0; addr = 16'h0040; wdata = 16'hCAFE;
        @(posedge clk);
        @(negedge clk);
        mem_wr = 0;
        reset = 1'b0;
        #1;
        n_tests += 4;
        if (ready !== 1'b0)  begin n_fail++; $display("FAIL midrst_ready: got %b, required 0", ready); end
        if (err !== 1'b0)    begin n_fail++; $display("FAIL midrst_err: got %b, required 0", err); end
        if (busy !== 1'b0)   begin n_fail++; $display("FAIL midrst_busy: got %b, required 0", busy); end
        if (rdata !== 16'h0) begin n_fail++; $display("FAIL midrst_rdata: got %h, required 0000", rdata); end
        repeat (4) @(negedge clk);
        reset = 1'b1;
        txn(1, 0, 0, 16'h0040, 16'h0, 16'h4321, 0, 1, ed, b1, be);
    endtask

    task automatic test_back_to_back();
        int ed;
        exp_t e;
        @(negedge clk);
        z_wr = 1; z_byte = 0; z_addr = 16'h0004; z_wdata = 16'h1357;
        e.rdata = 16'h0; e.err = 0; e.chk = 0;
        zq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        z_wr = 0;
        ed = 0;
        while (!z_ready && ed < 30) begin @(negedge clk); ed++; end
        n_tests++;
        if (ed !== 1) begin n_fail++; $display("FAIL z_latency: got %0d edges, required 1", ed); end
        @(negedge clk);
        // Hold the read request continuously across three transactions.
        @(negedge clk);
        z_rd = 1; z_addr = 16'h0004;
        e.rdata = 16'h1357; e.err = 0; e.chk = 1;
        repeat (3) zq.push_back(e);
        @(posedge clk);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            n_tests += 2;
            if (z_ready !== (i % 3 == 1)) begin
                n_fail++; $display("FAIL b2b_ready[%0d]: got %b, required %b", i, z_ready, (i % 3 == 1));
            end
            if (z_busy !== (i % 3 != 2)) begin
                n_fail++; $display("FAIL b2b_busy[%0d]: got %b, required %b", i, z_busy, (i % 3 != 2));
            end
            if (i == 8) z_rd = 0;
        end
        repeat (4) @(negedge clk);
        n_tests++;
        if (zq.size() !== 0) begin
            n_fail++; $display("FAIL b2b_pending: got %0d unanswered, required 0", zq.size());
        end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_errors();
        test_wrap_ignore();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        n_tests++;
        if (q.size() !== 0) begin
            n_fail++; $display("FAIL pending_responses: got %0d unanswered, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
